// File: rtl/collision_scan_controller_pkg.sv
// Shared constants and FSM state type for the asteroid collision scan.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package collision_scan_controller_pkg;

  localparam int NUM_OBJ = 16;                   // asteroid slots scanned per frame
  localparam int ROWS    = 160;                  // bitmap rows per object
  localparam int COLS    = 180;                  // bitmap row width in bits
  localparam int SLOT_W  = $clog2(NUM_OBJ + 1);  // must also hold the terminal value NUM_OBJ
  localparam int ROW_W   = $clog2(ROWS);
  localparam int IDX_W   = $clog2(NUM_OBJ);      // bits needed to index a real slot

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SCAN,
    FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/collision_scan_controller_if.sv
// Bundle of frame request, frame-memory read port and per-frame result signals.
// Latency: n/a (wiring only).
// Backpressure: none; memory answers a fixed one cycle after each read strobe.
// Ports: master = scan controller side, slave = frame logic / memory / game-state side.
interface collision_scan_controller_if;
  import collision_scan_controller_pkg::*;

  logic               start;
  logic [NUM_OBJ-1:0] active_mask;
  logic               rd_en;
  logic [SLOT_W-1:0]  rd_slot;
  logic [ROW_W-1:0]   rd_row;
  logic [COLS-1:0]    ast_row_data;
  logic [COLS-1:0]    ship_row_data;
  logic [COLS-1:0]    bullet_row_data;
  logic               busy;
  logic               done;
  logic               ship_hit;
  logic [NUM_OBJ-1:0] ship_hit_mask;
  logic [NUM_OBJ-1:0] bullet_hit_mask;

  modport master (
    input  start, active_mask, ast_row_data, ship_row_data, bullet_row_data,
    output rd_en, rd_slot, rd_row, busy, done, ship_hit, ship_hit_mask, bullet_hit_mask
  );

  modport slave (
    output start, active_mask, ast_row_data, ship_row_data, bullet_row_data,
    input  rd_en, rd_slot, rd_row, busy, done, ship_hit, ship_hit_mask, bullet_hit_mask
  );

endinterface

// File: rtl/collision_scan_controller_row_overlap.sv
// Row overlap test: any common set pixel between asteroid row and ship / bullet row.
// Latency: combinational.
// Backpressure: none.
// Ports: ast/ship/bullet row bitmaps in, ship_ov/bullet_ov flags out.
module row_overlap_unit
  import collision_scan_controller_pkg::*;
(
  input  logic [COLS-1:0] ast,
  input  logic [COLS-1:0] ship,
  input  logic [COLS-1:0] bullet,
  output logic            ship_ov,
  output logic            bullet_ov
);

  // Overlap means a shared set bit, not equal rows.
  assign ship_ov   = |(ast & ship);
  assign bullet_ov = |(ast & bullet);

endmodule

// File: rtl/collision_scan_controller.sv
// Per-frame collision scheduler: walks active slots row by row through one overlap unit.
// Latency: done in cycle 1 + (NUM_OBJ+1) + popcount(mask)*(ROWS+1) after start is sampled.
// Backpressure: none; start is ignored while busy or in the done cycle, nothing is queued.
// Ports: clock, reset (sync, active-high); bus.master carries start/mask, read port, results.
module collision_scan_controller
  import collision_scan_controller_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  collision_scan_controller_if.master bus
);

  state_t             state;
  logic [SLOT_W-1:0]  slot;
  logic [ROW_W-1:0]   row;
  logic [NUM_OBJ-1:0] mask_q;
  logic [NUM_OBJ-1:0] acc_ship;
  logic [NUM_OBJ-1:0] acc_bullet;
  logic [NUM_OBJ-1:0] ship_mask_q;
  logic [NUM_OBJ-1:0] bullet_mask_q;
  logic               rd_en_q;
  logic               rd_vld;      // row data on the bus this cycle belongs to last cycle's read
  logic               busy_q;
  logic               done_q;
  logic               ship_hit_q;
  logic               ship_ov;
  logic               bullet_ov;
  logic [IDX_W-1:0]   slot_idx;

  // Slot never changes between a read and its data cycle, so it also addresses the accumulator.
  assign slot_idx = slot[IDX_W-1:0];

  row_overlap_unit u_overlap (
    .ast       (bus.ast_row_data),
    .ship      (bus.ship_row_data),
    .bullet    (bus.bullet_row_data),
    .ship_ov   (ship_ov),
    .bullet_ov (bullet_ov)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      slot          <= '0;
      row           <= '0;
      mask_q        <= '0;
      acc_ship      <= '0;
      acc_bullet    <= '0;
      ship_mask_q   <= '0;
      bullet_mask_q <= '0;
      rd_en_q       <= 1'b0;
      rd_vld        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ship_hit_q    <= 1'b0;
    end else begin
      rd_vld <= rd_en_q;
      done_q <= 1'b0;

      if (rd_vld) begin
        acc_ship[slot_idx]   <= acc_ship[slot_idx] | ship_ov;
        acc_bullet[slot_idx] <= acc_bullet[slot_idx] | bullet_ov;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q     <= bus.active_mask;
            acc_ship   <= '0;
            acc_bullet <= '0;
            slot       <= '0;
            busy_q     <= 1'b1;
            state      <= SELECT;
          end
        end

        SELECT: begin
          if (slot == SLOT_W'(NUM_OBJ)) begin
            // Accumulators already hold the final FLUSH row here.
            ship_mask_q   <= acc_ship;
            bullet_mask_q <= acc_bullet;
            ship_hit_q    <= |acc_ship;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state         <= DONE;
          end else if (mask_q[slot_idx]) begin
            row     <= '0;
            rd_en_q <= 1'b1;
            state   <= SCAN;
          end else begin
            slot <= slot + 1'b1;
          end
        end

        SCAN: begin
          if (row == ROW_W'(ROWS - 1)) begin
            rd_en_q <= 1'b0;
            state   <= FLUSH;
          end else begin
            row <= row + 1'b1;
          end
        end

        FLUSH: begin
          slot  <= slot + 1'b1;
          state <= SELECT;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en           = rd_en_q;
  assign bus.rd_slot         = slot;
  assign bus.rd_row          = row;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.ship_hit        = ship_hit_q;
  assign bus.ship_hit_mask   = ship_mask_q;
  assign bus.bullet_hit_mask = bullet_mask_q;

endmodule
